// File: rtl/ysyx_22051086_lsu_stage.sv
// Load/store pipeline stage: issues the data-memory read for loads, aligns and extends
// the returned beat, selects the writeback result and drives the LS forwarding bus.
module ysyx_22051086_lsu_stage #(
  parameter int BUS_IN_W  = 348,
  parameter int BUS_OUT_W = 134,
  parameter int FWD_W     = 71
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_to_ls_valid,
  output logic                 ls_allowin,
  input  logic [BUS_IN_W-1:0]  ex_to_ls_bus,
  input  logic                 wb_allowin,
  output logic                 ls_to_wb_valid,
  output logic [BUS_OUT_W-1:0] ls_to_wb_bus,
  output logic                 dmem_rreq,
  output logic [63:0]          dmem_raddr,
  input  logic                 dmem_rready,
  input  logic                 dmem_rvalid,
  input  logic [63:0]          dmem_rdata,
  output logic [FWD_W-1:0]     ls_fwd_bus
);

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] raddr;
    logic [63:0] waddr;
    logic [7:0]  wmask;
    logic        load;
    logic        ld;
    logic        lwu;
    logic        lw;
    logic        lh;
    logic        lhu;
    logic        lbu;
    logic        lb;
    logic [2:0]  raddr_offset;
    logic        store;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic        csr;
    logic [63:0] csr_rdata;
    logic        special_64;
    logic [63:0] alu_res;
  } ex_bus_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  ex_bus_t     in_bus;
  ex_bus_t     bus_q, bus_d;
  state_e      state_q, state_d;
  logic        ls_valid_q, ls_valid_d;
  logic [63:0] data_buf_q, data_buf_d;
  logic        ls_ready_go;
  logic        capture;
  logic [63:0] shifted;
  logic [63:0] load_data;
  logic [63:0] result;
  logic        block_valid;
  logic        wen_valid;
  logic        unused_bits;

  assign in_bus = ex_to_ls_bus;

  // Ready-to-go is only asserted where the stage holds a final result.
  always_comb begin
    ls_ready_go = 1'b0;
    case (state_q)
      IDLE:    ls_ready_go = 1'b1;
      DONE:    ls_ready_go = 1'b1;
      default: ls_ready_go = 1'b0;
    endcase
  end

  assign ls_allowin     = !ls_valid_q || (ls_ready_go && wb_allowin);
  assign capture        = ex_to_ls_valid && ls_allowin;
  assign ls_to_wb_valid = ls_valid_q && ls_ready_go;

  // Next-state logic for the pipeline latch and the read-request FSM.
  always_comb begin
    state_d    = state_q;
    ls_valid_d = ls_valid_q;
    bus_d      = bus_q;
    data_buf_d = data_buf_q;
    if (ls_allowin) begin
      ls_valid_d = ex_to_ls_valid;
    end else begin
      ls_valid_d = ls_valid_q;
    end
    if (capture) begin
      bus_d = in_bus;
    end else begin
      bus_d = bus_q;
    end
    case (state_q)
      IDLE, DONE: begin
        // A late response here is dropped; only a fresh load capture starts a request.
        if (ls_allowin) begin
          state_d = (capture && in_bus.load) ? REQ : IDLE;
        end else begin
          state_d = state_q;
        end
      end
      REQ: begin
        if (dmem_rready && dmem_rvalid) begin
          state_d    = DONE;
          data_buf_d = dmem_rdata;
        end else if (dmem_rready) begin
          state_d = WAIT;
        end else begin
          state_d = state_q;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          state_d    = DONE;
          data_buf_d = dmem_rdata;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and read buffer, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ls_valid_q <= 1'b0;
      data_buf_q <= 64'd0;
    end else begin
      state_q    <= state_d;
      ls_valid_q <= ls_valid_d;
      data_buf_q <= data_buf_d;
    end
  end

  // Instruction payload latch; qualified by ls_valid_q so it needs no reset.
  always_ff @(posedge clk) begin
    bus_q <= bus_d;
  end

  assign dmem_rreq  = (state_q == REQ);
  assign dmem_raddr = {bus_q.raddr[63:3], 3'b000};

  // Aligned sub-word accesses all start at byte offset o, so one shift serves them all.
  assign shifted = data_buf_q >> {bus_q.raddr_offset, 3'b000};

  // Load extraction and result selection.
  always_comb begin
    load_data = data_buf_q;
    result    = bus_q.alu_res;
    if (bus_q.ld) begin
      load_data = data_buf_q;
    end else if (bus_q.lw) begin
      load_data = {{32{shifted[31]}}, shifted[31:0]};
    end else if (bus_q.lwu) begin
      load_data = {32'd0, shifted[31:0]};
    end else if (bus_q.lh) begin
      load_data = {{48{shifted[15]}}, shifted[15:0]};
    end else if (bus_q.lhu) begin
      load_data = {48'd0, shifted[15:0]};
    end else if (bus_q.lb) begin
      load_data = {{56{shifted[7]}}, shifted[7:0]};
    end else if (bus_q.lbu) begin
      load_data = {56'd0, shifted[7:0]};
    end else begin
      load_data = data_buf_q;
    end
    if (bus_q.load) begin
      result = load_data;
    end else if (bus_q.csr) begin
      result = bus_q.csr_rdata;
    end else if (bus_q.special_64) begin
      result = {{32{bus_q.alu_res[31]}}, bus_q.alu_res[31:0]};
    end else begin
      result = bus_q.alu_res;
    end
  end

  assign ls_to_wb_bus = {bus_q.pc, bus_q.reg_wen, bus_q.reg_waddr, result};

  assign block_valid = ls_valid_q && bus_q.load && (state_q != DONE);
  assign wen_valid   = ls_valid_q && bus_q.reg_wen;
  assign ls_fwd_bus  = ls_valid_q ? {block_valid, wen_valid, bus_q.reg_waddr, result}
                                  : {FWD_W{1'b0}};

  assign unused_bits = ^{bus_q.raddr[2:0], bus_q.waddr, bus_q.wmask, bus_q.store,
                         shifted[63:32]};

endmodule

// File: tb/tb_ysyx_22051086_lsu_stage.sv
// Self-checking bench for the LS stage: table of single instructions with a scoreboard,
// plus hand-written back-pressure and reset-during-WAIT sequences.
module tb_ysyx_22051086_lsu_stage;

  typedef enum int {OP_ALU, OP_LD, OP_LW, OP_LWU, OP_LH, OP_LHU, OP_LB, OP_LBU} op_e;

  typedef struct {
    string       name;
    op_e         op;
    logic [63:0] raddr;
    logic [63:0] rdata;
    int          wt;
    logic        csr;
    logic [63:0] csr_rd;
    logic        special;
    logic        store;
    logic        reg_wen;
    logic [4:0]  waddr;
    logic [63:0] alu;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         ex_to_ls_valid;
  logic         ls_allowin;
  logic [347:0] ex_to_ls_bus;
  logic         wb_allowin;
  logic         ls_to_wb_valid;
  logic [133:0] ls_to_wb_bus;
  logic         dmem_rreq;
  logic [63:0]  dmem_raddr;
  logic         dmem_rready;
  logic         dmem_rvalid;
  logic [63:0]  dmem_rdata;
  logic [70:0]  ls_fwd_bus;

  int checks = 0;
  int failures = 0;
  logic [133:0] exp_q[$];
  logic [133:0] got_q[$];
  logic [63:0]  addr_q[$];
  logic [63:0]  mem_data = 64'd0;
  int mem_wait = 0;
  int req_cnt = 0;
  int pulse_req = 0;
  int pulse_done = 0;
  bit pend = 1'b0;
  int cnt = 0;
  vec_t vecs[13];

  ysyx_22051086_lsu_stage dut (
    .clk(clk), .rst(rst),
    .ex_to_ls_valid(ex_to_ls_valid), .ls_allowin(ls_allowin), .ex_to_ls_bus(ex_to_ls_bus),
    .wb_allowin(wb_allowin), .ls_to_wb_valid(ls_to_wb_valid), .ls_to_wb_bus(ls_to_wb_bus),
    .dmem_rreq(dmem_rreq), .dmem_raddr(dmem_raddr), .dmem_rready(dmem_rready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .ls_fwd_bus(ls_fwd_bus)
  );

  always #5 clk = ~clk;

  // Data-memory responder: accepts each request, answers after mem_wait extra cycles.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      pend        = 1'b0;
      dmem_rready = 1'($urandom_range(0, 1));
      dmem_rvalid = 1'($urandom_range(0, 1));
      dmem_rdata  = {$urandom, $urandom};
    end else begin
      dmem_rready = 1'b0;
      dmem_rvalid = 1'b0;
      if (pulse_req != pulse_done) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = mem_data;
        pulse_done  = pulse_req;
      end else if (pend) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = mem_data;
          pend        = 1'b0;
        end
      end else if (dmem_rreq) begin
        dmem_rready = 1'b1;
        req_cnt     = req_cnt + 1;
        addr_q.push_back(dmem_raddr);
        if (mem_wait == 0) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = mem_data;
        end else begin
          pend = 1'b1;
          cnt  = mem_wait;
        end
      end
    end
  end

  // Output monitor: record every bus that is handed to writeback at the next edge.
  always @(negedge clk) begin
    if (rst === 1'b1 && ls_to_wb_valid === 1'b1 && wb_allowin === 1'b1) got_q.push_back(ls_to_wb_bus);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, wanted completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input op_e op, input logic [63:0] raddr,
                              input logic [63:0] rdata, input int wt, input logic csr,
                              input logic [63:0] csr_rd, input logic special, input logic store,
                              input logic reg_wen, input logic [4:0] waddr, input logic [63:0] alu,
                              input logic [63:0] exp, input int lat);
    vec_t v;
    v.name = n; v.op = op; v.raddr = raddr; v.rdata = rdata; v.wt = wt; v.csr = csr;
    v.csr_rd = csr_rd; v.special = special; v.store = store; v.reg_wen = reg_wen;
    v.waddr = waddr; v.alu = alu; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  function automatic logic [347:0] build_bus(input vec_t v, input logic [63:0] pc);
    logic is_load;
    is_load = (v.op != OP_ALU);
    return {pc, v.raddr, 64'h0, 8'h00, is_load, (v.op == OP_LD), (v.op == OP_LWU),
            (v.op == OP_LW), (v.op == OP_LH), (v.op == OP_LHU), (v.op == OP_LBU),
            (v.op == OP_LB), v.raddr[2:0], v.store, v.reg_wen, v.waddr, v.csr, v.csr_rd,
            v.special, v.alu};
  endfunction

  function automatic logic [133:0] sb_entry(input vec_t v, input logic [63:0] pc);
    return {pc, v.reg_wen, v.waddr, v.exp};
  endfunction

  task automatic sb_pop(input string n);
    if (got_q.size() == 0 || exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_sb: got %0d outputs for %0d expected", n, got_q.size(), exp_q.size());
      got_q.delete();
      exp_q.delete();
    end else begin
      chk(n, got_q.pop_front(), exp_q.pop_front());
    end
  endtask

  task automatic drive_capture(input logic [347:0] b, input string n, output bit ok);
    ex_to_ls_bus   = b;
    ex_to_ls_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ls_allowin === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_allowin: got 0 required 1 within 30 cycles", n);
      ex_to_ls_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic wait_valid(input bit is_load, output int lat, output bit seen, output bit blk_ok);
    lat = 0; seen = 1'b0; blk_ok = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ls_to_wb_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (is_load && ls_fwd_bus[70] !== 1'b1) blk_ok = 1'b0;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input logic [63:0] pc);
    bit ok, seen, blk_ok, is_load;
    int lat, r0;
    is_load  = (v.op != OP_ALU);
    mem_data = v.rdata;
    mem_wait = v.wt;
    r0 = req_cnt;
    drive_capture(build_bus(v, pc), v.name, ok);
    if (ok) begin
      exp_q.push_back(sb_entry(v, pc));
      #1 ex_to_ls_valid = 1'b0;
      wait_valid(is_load, lat, seen, blk_ok);
      chk({v.name, "_valid"}, 134'(seen), 134'(1));
      if (seen) begin
        chk({v.name, "_lat"}, 134'(lat), 134'(v.lat));
        if (is_load) chk({v.name, "_block_before_done"}, 134'(blk_ok), 134'(1));
        chk({v.name, "_block_at_done"}, 134'(ls_fwd_bus[70]), 134'(0));
        chk({v.name, "_wen_valid"}, 134'(ls_fwd_bus[69]), 134'(v.reg_wen));
        chk({v.name, "_allowin"}, 134'(ls_allowin), 134'(1));
        if (!is_load) chk({v.name, "_fwd_result"}, 134'(ls_fwd_bus[63:0]), 134'(v.exp));
        @(posedge clk);
        #1;
        sb_pop(v.name);
      end else begin
        exp_q.delete();
      end
      chk({v.name, "_reqs"}, 134'(req_cnt - r0), 134'(is_load ? 1 : 0));
      if (is_load && addr_q.size() > 0)
        chk({v.name, "_raddr"}, 134'(addr_q.pop_front()), 134'({v.raddr[63:3], 3'b000}));
    end
  endtask

  initial begin
    logic [351:0] rnd;
    bit ok, seen, blk_ok, bad_valid, bad_req;
    int lat, r0;
    vec_t bp_ld, bp_lw, rw_lw;

    // Capture-to-valid latency counted in clock edges after the capture edge.
    vecs[0]  = mk("lw_off4_wait1", OP_LW, 64'h8000_0004, 64'h8000_0001_0000_0002, 1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd10, 64'h8000_0004, 64'hFFFF_FFFF_8000_0001, 2);
    vecs[1]  = mk("lbu_off7", OP_LBU, 64'h8000_0107, 64'hAB00_0000_0000_0000, 0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd11, 64'h8000_0107, 64'h0000_0000_0000_00AB, 1);
    vecs[2]  = mk("addw", OP_ALU, 64'h0, 64'h0, 0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 5'd12, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000, 0);
    vecs[3]  = mk("lb_off7", OP_LB, 64'h8000_0207, 64'hAB00_0000_0000_0000, 0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd13, 64'h0, 64'hFFFF_FFFF_FFFF_FFAB, 1);
    vecs[4]  = mk("lhu_off2_wait2", OP_LHU, 64'h8000_0302, 64'h1122_3344_5566_7788, 2, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd14, 64'h0, 64'h0000_0000_0000_5566, 3);
    vecs[5]  = mk("lh_off6", OP_LH, 64'h8000_0406, 64'h8899_0000_0000_0000, 0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd15, 64'h0, 64'hFFFF_FFFF_FFFF_8899, 1);
    vecs[6]  = mk("lwu_off4", OP_LWU, 64'h8000_0504, 64'h8000_0001_0000_0002, 0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd16, 64'h0, 64'h0000_0000_8000_0001, 1);
    vecs[7]  = mk("ld_wait1", OP_LD, 64'h8000_1008, 64'hDEAD_BEEF_0123_4567, 1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd17, 64'h0, 64'hDEAD_BEEF_0123_4567, 2);
    vecs[8]  = mk("csr_over_special", OP_ALU, 64'h0, 64'h0, 0, 1'b1, 64'h0000_0000_0000_1234, 1'b1, 1'b0, 1'b1, 5'd18, 64'h0000_0000_0000_0055, 64'h0000_0000_0000_1234, 0);
    vecs[9]  = mk("alu_plain", OP_ALU, 64'h0, 64'h0, 0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd19, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0);
    vecs[10] = mk("store", OP_ALU, 64'h0, 64'h0, 0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 5'd0, 64'h0000_0000_8000_0010, 64'h0000_0000_8000_0010, 0);
    vecs[11] = mk("lw_off0_pos", OP_LW, 64'h8000_0600, 64'h1111_2222_7FFF_FFFF, 0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd20, 64'h0, 64'h0000_0000_7FFF_FFFF, 1);
    vecs[12] = mk("lb_off0_neg", OP_LB, 64'h8000_0700, 64'h0000_0000_0000_0080, 0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd21, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1);

    // Reset held with random inputs.
    rst = 1'b0; ex_to_ls_valid = 1'b0; wb_allowin = 1'b1; ex_to_ls_bus = 348'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int k = 0; k < 11; k++) rnd[k*32 +: 32] = $urandom;
      ex_to_ls_bus   = rnd[347:0];
      ex_to_ls_valid = 1'($urandom_range(0, 1));
      wb_allowin     = 1'($urandom_range(0, 1));
      #1;
      chk("rst_wb_valid", 134'(ls_to_wb_valid), 134'(0));
      chk("rst_rreq", 134'(dmem_rreq), 134'(0));
      chk("rst_fwd", 134'(ls_fwd_bus), 134'(0));
    end
    @(negedge clk);
    ex_to_ls_valid = 1'b0; wb_allowin = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], 64'h8000_1000 + 64'(i) * 64'd4);

    // Back-pressure: ld finishes while writeback stalls, lw queued behind it.
    bp_ld = mk("bp_ld", OP_LD, 64'h8000_2000, 64'hCAFE_F00D_1234_5678, 0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd5, 64'h0, 64'hCAFE_F00D_1234_5678, 1);
    bp_lw = mk("bp_lw", OP_LW, 64'h8000_2010, 64'h0000_0000_8765_4321, 0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd6, 64'h0, 64'hFFFF_FFFF_8765_4321, 1);
    wb_allowin = 1'b0; mem_data = bp_ld.rdata; mem_wait = 0; r0 = req_cnt;
    drive_capture(build_bus(bp_ld, 64'h8000_3000), "bp_ld", ok);
    if (ok) begin
      exp_q.push_back(sb_entry(bp_ld, 64'h8000_3000));
      #1 ex_to_ls_bus = build_bus(bp_lw, 64'h8000_3004);
      wait_valid(1'b1, lat, seen, blk_ok);
      chk("bp_ld_valid", 134'(seen), 134'(1));
      mem_data = bp_lw.rdata;
      for (int i = 0; i < 3; i++) begin
        if (i > 0) @(negedge clk);
        chk("bp_hold_valid", 134'(ls_to_wb_valid), 134'(1));
        chk("bp_hold_result", 134'(ls_to_wb_bus[63:0]), 134'(bp_ld.exp));
        chk("bp_hold_allowin", 134'(ls_allowin), 134'(0));
        chk("bp_hold_no_rreq", 134'(dmem_rreq), 134'(0));
      end
      @(posedge clk);
      #1 wb_allowin = 1'b1;
      @(negedge clk);
      chk("bp_handoff_allowin", 134'(ls_allowin), 134'(1));
      chk("bp_handoff_no_rreq", 134'(dmem_rreq), 134'(0));
      chk("bp_handoff_reqs", 134'(req_cnt - r0), 134'(1));
      @(posedge clk);
      exp_q.push_back(sb_entry(bp_lw, 64'h8000_3004));
      #1 ex_to_ls_valid = 1'b0;
      sb_pop("bp_ld");
      wait_valid(1'b1, lat, seen, blk_ok);
      chk("bp_lw_valid", 134'(seen), 134'(1));
      chk("bp_lw_lat", 134'(lat), 134'(1));
      @(posedge clk);
      #1;
      sb_pop("bp_lw");
      chk("bp_total_reqs", 134'(req_cnt - r0), 134'(2));
    end
    addr_q.delete();
    wb_allowin = 1'b1;

    // Reset asserted while waiting for read data, then a stray response after release.
    rw_lw = mk("rw_lw", OP_LW, 64'h8000_4000, 64'h0000_0000_1234_5678, 5, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 5'd7, 64'h0, 64'h0000_0000_1234_5678, 0);
    mem_data = rw_lw.rdata; mem_wait = 5;
    drive_capture(build_bus(rw_lw, 64'h8000_5000), "rw_lw", ok);
    if (ok) begin
      #1 ex_to_ls_valid = 1'b0;
      @(negedge clk);
      chk("rw_req", 134'(dmem_rreq), 134'(1));
      @(negedge clk);
      chk("rw_wait_no_rreq", 134'(dmem_rreq), 134'(0));
      chk("rw_wait_block", 134'(ls_fwd_bus[70]), 134'(1));
      rst = 1'b0;
      #1;
      chk("rw_rst_valid", 134'(ls_to_wb_valid), 134'(0));
      chk("rw_rst_fwd", 134'(ls_fwd_bus), 134'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 pulse_req = pulse_req + 1;
      bad_valid = 1'b0; bad_req = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        #1;
        if (ls_to_wb_valid !== 1'b0) bad_valid = 1'b1;
        if (dmem_rreq !== 1'b0) bad_req = 1'b1;
      end
      chk("rw_late_rvalid_no_valid", 134'(bad_valid), 134'(0));
      chk("rw_late_rvalid_no_rreq", 134'(bad_req), 134'(0));
      chk("rw_no_output", 134'(got_q.size()), 134'(0));
      chk("rw_allowin_idle", 134'(ls_allowin), 134'(1));
    end
    addr_q.delete();
    got_q.delete();
    exp_q.delete();
    mem_wait = 0;
    run_vec(vecs[2], 64'h8000_6000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
